section_loader: RTL and testbench

- Parametrised successor to the single-image boot loader.
- Consumes a byte stream from the UART receive side, parses one or more sections (target id, base address, byte size, payload), and writes payload words to one of NUM_TARGETS memories through a shared write port.
- Ends with a 32-bit additive checksum. Reports completion or a coded error.
- Sits between the UART RX block and the instruction/data memory write ports; the core is held until completed=1.

---
 rtl/section_loader.sv | 153 +++++++++++++++
 tb/tb_section_loader.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/section_loader.sv
// Multi-section boot loader: parses target/address/size headers from a UART
// byte stream, writes payload words to the selected memory, and verifies a trailing checksum.
module section_loader #(
  parameter int WORD_BYTES  = 4,
  parameter int ADDR_W      = 32,
  parameter int NUM_TARGETS = 2,
  parameter int TID_W       = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    completed,
  output logic                    error,
  output logic [1:0]              err_code,
  output logic [31:0]             words_written,
  output logic                    uart_out_valid,
  input  logic [7:0]              uart_out_data,
  input  logic                    uart_out_ready,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [8*WORD_BYTES-1:0] mem_data,
  output logic [TID_W-1:0]        mem_target,
  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic [3:0]              dbg_state
);

  localparam int          DW         = 8 * WORD_BYTES;
  localparam int          CW         = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [2:0]  LAST_W     = 3'(WORD_BYTES - 1);
  localparam logic [31:0] ALIGN_MASK = 32'(WORD_BYTES - 1);
  localparam logic [31:0] STEP       = 32'(WORD_BYTES);

  typedef enum logic [3:0] {
    S_INIT, S_HDR_TGT, S_HDR_ADDR, S_HDR_SIZE, S_PAYLOAD,
    S_STORE, S_CHECKSUM, S_DONE, S_ERROR
  } state_t;

  // Byte handshake: a byte moves on a posedge where uart_out_valid and
  // uart_out_ready are both 1; memory write moves when mem_valid and mem_ready are both 1.
  state_t            r_state, w_next;
  logic [2:0]        r_cnt;
  logic [31:0]       r_field;
  logic [DW-1:0]     r_word;
  logic [TID_W-1:0]  r_tgt;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_remaining;
  logic [31:0]       r_csum;

  logic              w_take, w_field_last, w_word_last, w_tgt_bad, w_misaligned, w_rx_next;
  logic [31:0]       w_field;
  logic [DW-1:0]     w_word;
  logic [1:0]        w_err_next;

  assign dbg_state    = r_state;
  assign w_take       = uart_out_valid & uart_out_ready;
  assign w_field_last = (r_cnt[1:0] == 2'd3);
  assign w_word_last  = (r_cnt == LAST_W);
  assign w_tgt_bad    = 32'(w_field[TID_W-1:0]) >= 32'(NUM_TARGETS);
  assign w_misaligned = ((w_field & ALIGN_MASK) != 32'd0) || ((32'(r_addr) & ALIGN_MASK) != 32'd0);

  // Fields are little-endian: byte n of a field lands in bits [8n+7:8n].
  always_comb begin
    w_field = r_field;
    w_field[8*r_cnt[1:0] +: 8] = uart_out_data;
    w_word = r_word;
    w_word[8*r_cnt[CW-1:0] +: 8] = uart_out_data;
  end

  always_comb begin
    w_next     = r_state;
    w_err_next = 2'd0;
    case (r_state)
      S_INIT:     w_next = S_HDR_TGT;
      S_HDR_TGT:  if (w_take && w_field_last) begin
                    if (w_tgt_bad) begin w_next = S_ERROR; w_err_next = 2'd1; end
                    else w_next = S_HDR_ADDR;
                  end
      S_HDR_ADDR: if (w_take && w_field_last) w_next = S_HDR_SIZE;
      S_HDR_SIZE: if (w_take && w_field_last) begin
                    if (w_field == 32'd0) w_next = S_CHECKSUM;
                    else if (w_misaligned) begin w_next = S_ERROR; w_err_next = 2'd2; end
                    else w_next = S_PAYLOAD;
                  end
      S_PAYLOAD:  if (w_take && w_word_last) w_next = S_STORE;
      S_STORE:    if (mem_ready) w_next = (r_remaining == STEP) ? S_HDR_TGT : S_PAYLOAD;
      S_CHECKSUM: if (w_take && w_field_last) begin
                    if (w_field == r_csum) w_next = S_DONE;
                    else begin w_next = S_ERROR; w_err_next = 2'd3; end
                  end
      S_DONE:     w_next = S_DONE;
      S_ERROR:    w_next = S_ERROR;
      default:    w_next = S_INIT;
    endcase
  end

  assign w_rx_next = (w_next == S_HDR_TGT) || (w_next == S_HDR_ADDR) || (w_next == S_HDR_SIZE) ||
                     (w_next == S_PAYLOAD) || (w_next == S_CHECKSUM);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= S_INIT;
      r_cnt          <= '0;
      r_field        <= '0;
      r_word         <= '0;
      r_tgt          <= '0;
      r_addr         <= '0;
      r_remaining    <= '0;
      r_csum         <= '0;
      completed      <= 1'b0;
      error          <= 1'b0;
      err_code       <= 2'd0;
      words_written  <= '0;
      uart_out_valid <= 1'b0;
      mem_addr       <= '0;
      mem_data       <= '0;
      mem_target     <= '0;
      mem_valid      <= 1'b0;
    end else begin
      r_state        <= w_next;
      uart_out_valid <= w_rx_next;
      completed      <= (w_next == S_DONE);
      error          <= (w_next == S_ERROR);
      if (w_next == S_ERROR && r_state != S_ERROR) err_code <= w_err_next;
      if (w_take) begin
        r_field <= w_field;
        r_word  <= w_word;
        if (r_state == S_PAYLOAD) r_cnt <= w_word_last ? 3'd0 : r_cnt + 3'd1;
        else                      r_cnt <= w_field_last ? 3'd0 : r_cnt + 3'd1;
      end
      case (r_state)
        S_HDR_TGT:  if (w_take && w_field_last) r_tgt <= w_field[TID_W-1:0];
        S_HDR_ADDR: if (w_take && w_field_last) r_addr <= ADDR_W'(w_field);
        S_HDR_SIZE: if (w_take && w_field_last) r_remaining <= w_field;
        S_PAYLOAD:  if (w_take) begin
                      r_csum <= r_csum + 32'(uart_out_data);
                      if (w_word_last) begin
                        mem_valid  <= 1'b1;
                        mem_addr   <= r_addr;
                        mem_data   <= w_word;
                        mem_target <= r_tgt;
                      end
                    end
        S_STORE:    if (mem_ready) begin
                      mem_valid     <= 1'b0;
                      words_written <= words_written + 32'd1;
                      r_addr        <= r_addr + ADDR_W'(WORD_BYTES);
                      r_remaining   <= r_remaining - STEP;
                    end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_section_loader.sv
// Directed bench for section_loader: a stream-level model predicts writes and final status
// for a 4-byte-word instance and an 8-byte-word instance driven from one shared feeder.
module tb_section_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n = 1'b0;
  logic       use_b = 1'b0;
  logic [7:0] uart_data = 8'h0;
  logic       uart_rdy = 1'b0;
  logic       mem_rdy = 1'b0;
  int         stall_cfg = 0;

  logic        a_completed, a_error, a_uvalid, a_mvalid, a_urdy, a_mrdy;
  logic [1:0]  a_err_code;
  logic [31:0] a_words, a_maddr, a_mdata;
  logic [3:0]  a_mtgt, a_dbg;
  logic        b_completed, b_error, b_uvalid, b_mvalid, b_urdy, b_mrdy;
  logic [1:0]  b_err_code;
  logic [31:0] b_words, b_maddr;
  logic [63:0] b_mdata;
  logic [3:0]  b_mtgt, b_dbg;

  assign a_urdy = uart_rdy & ~use_b;
  assign b_urdy = uart_rdy & use_b;
  assign a_mrdy = mem_rdy & ~use_b;
  assign b_mrdy = mem_rdy & use_b;

  section_loader #(.WORD_BYTES(4)) dut_a (
    .clk(clk), .reset(reset_n), .completed(a_completed), .error(a_error), .err_code(a_err_code),
    .words_written(a_words), .uart_out_valid(a_uvalid), .uart_out_data(uart_data),
    .uart_out_ready(a_urdy), .mem_addr(a_maddr), .mem_data(a_mdata), .mem_target(a_mtgt),
    .mem_valid(a_mvalid), .mem_ready(a_mrdy), .dbg_state(a_dbg));

  section_loader #(.WORD_BYTES(8)) dut_b (
    .clk(clk), .reset(reset_n), .completed(b_completed), .error(b_error), .err_code(b_err_code),
    .words_written(b_words), .uart_out_valid(b_uvalid), .uart_out_data(uart_data),
    .uart_out_ready(b_urdy), .mem_addr(b_maddr), .mem_data(b_mdata), .mem_target(b_mtgt),
    .mem_valid(b_mvalid), .mem_ready(b_mrdy), .dbg_state(b_dbg));

  logic        cur_completed, cur_error, cur_uvalid, cur_mvalid;
  logic [1:0]  cur_err_code;
  logic [31:0] cur_words, cur_maddr;
  logic [63:0] cur_mdata;
  logic [3:0]  cur_mtgt;
  assign cur_completed = use_b ? b_completed : a_completed;
  assign cur_error     = use_b ? b_error : a_error;
  assign cur_err_code  = use_b ? b_err_code : a_err_code;
  assign cur_words     = use_b ? b_words : a_words;
  assign cur_uvalid    = use_b ? b_uvalid : a_uvalid;
  assign cur_mvalid    = use_b ? b_mvalid : a_mvalid;
  assign cur_maddr     = use_b ? b_maddr : a_maddr;
  assign cur_mdata     = use_b ? b_mdata : {32'h0, a_mdata};
  assign cur_mtgt      = use_b ? b_mtgt : a_mtgt;

  int errors = 0;
  int checks = 0;

  logic [7:0]  byte_q[$];
  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_data_q[$];
  logic [3:0]  exp_tgt_q[$];
  logic [31:0] bld_sum;
  bit          m_done;
  int          m_err, m_words;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] get32(input int p);
    return {byte_q[p+3], byte_q[p+2], byte_q[p+1], byte_q[p]};
  endfunction

  task automatic add32(input logic [31:0] v);
    for (int i = 0; i < 4; i++) byte_q.push_back(v[8*i +: 8]);
  endtask

  task automatic add_sec(input logic [31:0] t, input logic [31:0] a, input logic [31:0] s,
                         input logic [7:0] first);
    add32(t); add32(a); add32(s);
    for (int i = 0; i < int'(s); i++) begin
      byte_q.push_back(first + 8'(i));
      bld_sum = bld_sum + 32'(first + 8'(i));
    end
  endtask

  task automatic add_end(input logic [31:0] delta);
    add32(0); add32(0); add32(0); add32(bld_sum + delta);
  endtask

  // Stream-level reading of the format: walk sections, predict every write and the final status.
  task automatic model_run(input int wb);
    int p = 0;
    bit stop = 0;
    logic [31:0] t, a, s, sum;
    logic [63:0] data;
    sum = 0; m_done = 0; m_err = 0; m_words = 0;
    exp_addr_q.delete(); exp_data_q.delete(); exp_tgt_q.delete();
    while (!stop && p + 4 <= byte_q.size()) begin
      t = get32(p);
      if (t[3:0] >= 4'd2) begin m_err = 1; break; end
      if (p + 12 > byte_q.size()) break;
      a = get32(p + 4);
      s = get32(p + 8);
      if (s == 0) begin
        if (p + 16 <= byte_q.size()) begin
          if (get32(p + 12) == sum) m_done = 1; else m_err = 3;
        end
        break;
      end
      if ((s % wb) != 0 || (a % wb) != 0) begin m_err = 2; break; end
      p += 12;
      for (int w = 0; w < int'(s) / wb; w++) begin
        if (p + wb > byte_q.size()) begin stop = 1; break; end
        data = 0;
        for (int k = 0; k < wb; k++) begin
          data[8*k +: 8] = byte_q[p+k];
          sum = sum + 32'(byte_q[p+k]);
        end
        exp_addr_q.push_back(a + 32'(w * wb));
        exp_data_q.push_back(data);
        exp_tgt_q.push_back(t[3:0]);
        m_words++;
        p += wb;
      end
    end
  endtask

  // Driver and compare process: feeds bytes, answers writes, checks every active cycle.
  int          feed_idx, stall_left, acc_count;
  bit          prev_stall;
  logic [31:0] prev_addr;
  logic [63:0] prev_data;
  logic [3:0]  prev_tgt;
  always @(negedge clk) begin
    if (!reset_n) begin
      feed_idx = 0; uart_rdy = 0; mem_rdy = 0; stall_left = stall_cfg;
      acc_count = 0; prev_stall = 0;
    end else begin
      if (feed_idx < byte_q.size()) begin
        uart_data = byte_q[feed_idx];
        uart_rdy = 1;
        if (cur_uvalid) feed_idx++;
      end else uart_rdy = 0;
      if (cur_mvalid && stall_left > 0) begin mem_rdy = 0; stall_left--; end
      else mem_rdy = 1;
      if (prev_stall) begin
        chk("stall_valid", cur_mvalid, 1);
        chk("stall_addr", cur_maddr, prev_addr);
        chk("stall_data", cur_mdata, prev_data);
        chk("stall_tgt", cur_mtgt, prev_tgt);
      end
      if (cur_mvalid) chk("uart_idle_in_store", cur_uvalid, 0);
      chk("words_written", cur_words, acc_count);
      if (cur_mvalid && mem_rdy) begin
        if (exp_addr_q.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          chk("wr_addr", cur_maddr, exp_addr_q.pop_front());
          chk("wr_data", cur_mdata, exp_data_q.pop_front());
          chk("wr_tgt", cur_mtgt, exp_tgt_q.pop_front());
        end
        acc_count++;
      end
      prev_stall = cur_mvalid && !mem_rdy;
      prev_addr = cur_maddr; prev_data = cur_mdata; prev_tgt = cur_mtgt;
    end
  end

  task automatic begin_test(input bit b, input int stall);
    @(negedge clk);
    reset_n = 0; use_b = b; stall_cfg = stall;
    @(posedge clk);
    @(negedge clk);
    chk("rst_status", {a_completed, a_error, a_err_code, a_uvalid, a_mvalid,
                       b_completed, b_error, b_err_code, b_uvalid, b_mvalid}, 0);
    chk("rst_words", {a_words, b_words}, 0);
    chk("rst_mem_a", {a_maddr, a_mtgt}, 0);
    chk("rst_mem_b", {b_maddr, b_mtgt}, 0);
    chk("rst_data", a_mdata | b_mdata[31:0] | b_mdata[63:32], 0);
    byte_q.delete();
    bld_sum = 0;
  endtask

  task automatic release_and_finish();
    int n = 0;
    @(negedge clk);
    reset_n = 1;
    while (!(cur_completed || cur_error) && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL timeout: got no completion expected completed or error");
    end
    repeat (4) @(negedge clk);
    chk("fin_completed", cur_completed, m_done);
    chk("fin_error", cur_error, m_err != 0);
    chk("fin_err_code", cur_err_code, m_err);
    chk("fin_words", cur_words, m_words);
    chk("fin_pending", exp_addr_q.size(), 0);
    chk("fin_uvalid", cur_uvalid, 0);
    chk("fin_mvalid", cur_mvalid, 0);
  endtask

  task automatic release_truncated();
    int n = 0;
    @(negedge clk);
    reset_n = 1;
    while (feed_idx < byte_q.size() && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) begin
      checks++; errors++;
      $display("FAIL feed_timeout: got %0d bytes expected %0d", feed_idx, byte_q.size());
    end
    repeat (3) @(negedge clk);
    chk("trunc_mvalid", cur_mvalid, 0);
    chk("trunc_words", cur_words, 0);
  endtask

  initial begin
    // One section, two words.
    begin_test(0, 0);
    add_sec(0, 32'h100, 8, 8'h01); add_end(0);
    model_run(4);
    chk("pin_sum", bld_sum, 32'h24);
    chk("pin_n", exp_addr_q.size(), 2);
    chk("pin_d0", exp_data_q[0], 64'h04030201);
    chk("pin_a1", exp_addr_q[1], 32'h104);
    chk("pin_d1", exp_data_q[1], 64'h08070605);
    release_and_finish();
    chk("t1_completed", cur_completed, 1);
    chk("t1_words", cur_words, 2);

    // Two sections to different targets.
    begin_test(0, 0);
    add_sec(0, 32'h0, 4, 8'h11); add_sec(1, 32'h40, 4, 8'h21); add_end(0);
    model_run(4);
    chk("pin_t2_tgt1", exp_tgt_q[1], 4'd1);
    chk("pin_t2_d1", exp_data_q[1], 64'h24232221);
    release_and_finish();
    chk("t2_completed", cur_completed, 1);

    // Five-cycle stall on the first write.
    begin_test(0, 5);
    add_sec(0, 32'h100, 8, 8'h01); add_end(0);
    model_run(4);
    release_and_finish();
    chk("t3_words", cur_words, 2);

    // Bad target id.
    begin_test(0, 0);
    add_sec(5, 32'h100, 8, 8'h01); add_end(0);
    model_run(4);
    release_and_finish();
    chk("t4_code", cur_err_code, 1);

    // Size not a word multiple, then misaligned base.
    begin_test(0, 0);
    add_sec(0, 32'h0, 6, 8'h01); add_end(0);
    model_run(4);
    release_and_finish();
    chk("t5_code", cur_err_code, 2);
    begin_test(0, 0);
    add_sec(0, 32'h102, 8, 8'h01); add_end(0);
    model_run(4);
    release_and_finish();
    chk("t5b_code", cur_err_code, 2);

    // Checksum off by one after two good writes.
    begin_test(0, 0);
    add_sec(0, 32'h0, 4, 8'h11); add_sec(1, 32'h40, 4, 8'h21); add_end(1);
    model_run(4);
    release_and_finish();
    chk("t6_code", cur_err_code, 3);
    chk("t6_completed", cur_completed, 0);
    chk("t6_words", cur_words, 2);

    // Reset mid-payload, then a clean stream (4-byte words).
    begin_test(0, 0);
    add_sec(0, 32'h100, 8, 8'h01);
    while (byte_q.size() > 14) void'(byte_q.pop_back());
    model_run(4);
    release_truncated();
    begin_test(0, 0);
    add_sec(0, 32'h100, 8, 8'h01); add_end(0);
    model_run(4);
    release_and_finish();
    chk("t7_words", cur_words, 2);

    // Same with 8-byte words: 16-byte payload, stride 8.
    begin_test(1, 0);
    add_sec(1, 32'h200, 16, 8'h31);
    while (byte_q.size() > 14) void'(byte_q.pop_back());
    model_run(8);
    release_truncated();
    begin_test(1, 2);
    add_sec(1, 32'h200, 16, 8'h31); add_end(0);
    model_run(8);
    chk("pin_b_d0", exp_data_q[0], 64'h3837363534333231);
    chk("pin_b_a1", exp_addr_q[1], 32'h208);
    release_and_finish();
    chk("t8_completed", cur_completed, 1);
    chk("t8_words", cur_words, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
